spi_flash_se_slave: RTL

SPI_FLASH_SE_SLAVE -- requirements
Module: spi_flash_se_slave

---
 rtl/spi_flash_se_slave_if.sv | 14 +
 rtl/spi_flash_se_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_se_slave_if.sv
// SPI bus between a flash master and the sector-erase slave model.
//   sck  : serial clock, mode 0 (idle low), master -> slave
//   cs_n : chip select, active-low, master -> slave
//   mosi : serial data, MSB first, master -> slave
//   miso : serial data, MSB first, slave -> master
interface spi_flash_se_slave_if;
  logic sck;
  logic cs_n;
  logic mosi;
  logic miso;

  modport slave  (input  sck, input  cs_n, input  mosi, output miso);
  modport master (output sck, output cs_n, output mosi, input  miso);
endinterface

// File: rtl/spi_flash_se_slave.sv
// SPI flash slave model: WREN, WRDI, SE (sector erase), RDSR, and optionally RDID.
// All SPI inputs are oversampled in the sys_clk domain through 2-flop synchronizers.
// Write-type commands commit when the synchronized cs_n rises.
//
// Ports:
//   sys_clk, sys_rst_n : system clock, asynchronous active-low reset
//   spi (slave)        : sck / cs_n / mosi in, miso out
//   erase_req          : one-cycle pulse on an accepted sector erase
//   erase_addr[23:0]   : address of the last accepted erase
//   wel, wip           : write-enable latch, write/erase in progress
//   cmd_err            : one-cycle pulse on a rejected or malformed command
//
// Build option: define FLASH_RDID_EN to serve RDID (0x9F), which returns JEDEC_ID.
// Without it, 0x9F is treated as an unknown opcode.
module spi_flash_se_slave #(
  parameter int unsigned ERASE_CYCLES = 1000,
  parameter logic [23:0] JEDEC_ID     = 24'h202015
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  spi_flash_se_slave_if.slave  spi,
  output logic                 erase_req,
  output logic [23:0]          erase_addr,
  output logic                 wel,
  output logic                 wip,
  output logic                 cmd_err
);

`ifdef FLASH_RDID_EN
  localparam bit RDID_EN = 1'b1;
`else
  localparam bit RDID_EN = 1'b0;
`endif

  localparam int unsigned TW = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'h9F;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DOUT, IGNORE} state_e;

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  state_e         state_q, state_d;
  logic [5:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     op_q, op_d;
  logic [23:0]    addr_q, addr_d;
  logic [23:0]    sh_q, sh_d;
  logic [2:0]     dcnt_q, dcnt_d;
  logic           miso_q, miso_d;
  logic           wel_q, wel_d;
  logic           wip_q, wip_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [23:0]    erase_addr_q, erase_addr_d;
  logic           erase_req_q, erase_req_d;
  logic           cmd_err_q, cmd_err_d;
  logic [1:0]     settle_q, settle_d;
  logic           armed_q, armed_d;

  logic       sck_rise, sck_fall, cs_fall, cs_rise;
  logic [7:0] status, op_next;

  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign cs_fall  = ~cs_sync_q & cs_prev_q;
  assign cs_rise  = cs_sync_q & ~cs_prev_q;
  assign status   = {6'b0, wel_q, wip_q};
  assign op_next  = {op_q[6:0], mosi_sync_q};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_meta_q    <= 1'b1;
      cs_sync_q    <= 1'b1;
      cs_prev_q    <= 1'b1;
      sck_meta_q   <= 1'b0;
      sck_sync_q   <= 1'b0;
      sck_prev_q   <= 1'b0;
      mosi_meta_q  <= 1'b0;
      mosi_sync_q  <= 1'b0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      sh_q         <= '0;
      dcnt_q       <= '0;
      miso_q       <= 1'b0;
      wel_q        <= 1'b0;
      wip_q        <= 1'b0;
      timer_q      <= '0;
      erase_addr_q <= '0;
      erase_req_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
    end else begin
      cs_meta_q    <= spi.cs_n;
      cs_sync_q    <= cs_meta_q;
      cs_prev_q    <= cs_sync_q;
      sck_meta_q   <= spi.sck;
      sck_sync_q   <= sck_meta_q;
      sck_prev_q   <= sck_sync_q;
      mosi_meta_q  <= spi.mosi;
      mosi_sync_q  <= mosi_meta_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      sh_q         <= sh_d;
      dcnt_q       <= dcnt_d;
      miso_q       <= miso_d;
      wel_q        <= wel_d;
      wip_q        <= wip_d;
      timer_q      <= timer_d;
      erase_addr_q <= erase_addr_d;
      erase_req_q  <= erase_req_d;
      cmd_err_q    <= cmd_err_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    sh_d         = sh_q;
    dcnt_d       = dcnt_q;
    miso_d       = miso_q;
    wel_d        = wel_q;
    wip_d        = wip_q;
    timer_d      = timer_q;
    erase_addr_d = erase_addr_q;
    erase_req_d  = 1'b0;
    cmd_err_d    = 1'b0;
    settle_d     = settle_q;
    armed_d      = armed_q;

    // A cs_n held low through reset must not look like a fresh select:
    // wait for the synchronizers to reflect the pin, then require cs_n high.
    if (settle_q != 2'd3) settle_d = settle_q + 2'd1;
    else if (cs_sync_q)   armed_d  = 1'b1;

    if (wip_q) begin
      if (timer_q == '0) begin
        wip_d = 1'b0;
        wel_d = 1'b0;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end

    if (cs_sync_q) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      // Commit sees pre-update wip_q, so a frame ending on the expiry cycle
      // is still rejected. Frames still in CMD (<8 bits) abort silently.
      if (cs_rise && state_q != IDLE && state_q != CMD) begin
        case (op_q)
          OP_WREN: if (bit_cnt_q == 6'd8 && !wip_q) wel_d = 1'b1; else cmd_err_d = 1'b1;
          OP_WRDI: if (bit_cnt_q == 6'd8 && !wip_q) wel_d = 1'b0; else cmd_err_d = 1'b1;
          OP_SE: begin
            if (bit_cnt_q == 6'd32 && wel_q && !wip_q) begin
              erase_addr_d = addr_q;
              erase_req_d  = 1'b1;
              wip_d        = 1'b1;
              timer_d      = TW'(ERASE_CYCLES - 1);
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          OP_RDSR: ;
          OP_RDID: if (!RDID_EN) cmd_err_d = 1'b1;
          default: cmd_err_d = 1'b1;
        endcase
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall && armed_q) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            op_d      = '0;
            addr_d    = '0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            op_d      = op_next;
            if (bit_cnt_q == 6'd7) begin
              case (op_next)
                OP_SE:   state_d = ADDR;
                OP_RDSR: begin
                  state_d = DOUT;
                  sh_d    = {status, 16'h0};
                  dcnt_d  = '0;
                  miso_d  = 1'b0;
                end
                OP_RDID: begin
                  if (RDID_EN) begin
                    state_d = DOUT;
                    sh_d    = JEDEC_ID;
                    dcnt_d  = '0;
                    miso_d  = 1'b0;
                  end else begin
                    state_d = IGNORE;
                  end
                end
                default: state_d = IGNORE;
              endcase
            end
          end
        end
        default: begin
          if (sck_rise) begin
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 6'd1;
            if (state_q == ADDR && bit_cnt_q < 6'd32) addr_d = {addr_q[22:0], mosi_sync_q};
          end
          if (state_q == DOUT && sck_fall) begin
            miso_d = sh_q[23];
            dcnt_d = dcnt_q + 3'd1;
            // RDSR refreshes the live status at every byte boundary.
            if (op_q == OP_RDSR && dcnt_q == 3'd7) sh_d = {status, 16'h0};
            else                                   sh_d = {sh_q[22:0], 1'b0};
          end
        end
      endcase
    end
  end

  assign spi.miso   = (state_q == DOUT) & miso_q;
  assign erase_req  = erase_req_q;
  assign erase_addr = erase_addr_q;
  assign wel        = wel_q;
  assign wip        = wip_q;
  assign cmd_err    = cmd_err_q;

endmodule
